// File: rtl/rf_burst_reader.sv
// rf_burst_reader: sweeps a register-file address window and streams each word on a valid/ready output.
// Optional feature macro BURST_RD_STRIDE_EN: adds a stride input and steps the read address by it (default stride 1).
// Ports: clk, reset (async, active-low); start/base/len/abort command inputs (stride when enabled);
//        rdaddr/ren/rddata combinational register-file read port; out_data/out_valid/out_ready output stream;
//        busy (not idle), done (pulse after last accepted word), err (pulse on rejected over-length start).
module rf_burst_reader #(
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] len,
`ifdef BURST_RD_STRIDE_EN
    input  logic [31:0] stride,
`endif
    input  logic        abort,
    output logic [31:0] rdaddr,
    output logic        ren,
    input  logic [31:0] rddata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d, len_q, len_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
    logic [31:0]      rd_ptr;
`ifdef BURST_RD_STRIDE_EN
    // running address accumulator avoids a base + idx*stride multiplier
    logic [31:0]      addr_q, addr_d, stride_q, stride_d;
    assign rd_ptr = addr_q;
`else
    logic [31:0]      base_q, base_d;
    assign rd_ptr = base_q + 32'(idx_q);
`endif
    // a read happens only when the word will be consumed, so stalls never re-read
    assign ren       = !abort && (state_q == FILL || (state_q == STREAM && out_ready && idx_q < len_q));
    assign rdaddr    = ren ? rd_ptr : '0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign err       = err_q;
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
`ifdef BURST_RD_STRIDE_EN
        addr_d      = addr_q;
        stride_d    = stride_q;
`else
        base_d      = base_q;
`endif
        if (state_q == IDLE && start) begin
            if (len > 32'(MAX_LEN)) begin
                err_d = 1'b1;
            end else if (len == 32'd0) begin
                state_d = DONE;
            end else begin
                len_d   = len[CNT_W-1:0];
                idx_d   = '0;
                state_d = FILL;
`ifdef BURST_RD_STRIDE_EN
                addr_d   = base;
                stride_d = stride;
`else
                base_d   = base;
`endif
            end
        end else if ((state_q == FILL || state_q == STREAM) && abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (ren) begin
            out_data_d  = rddata;
            out_valid_d = 1'b1;
            idx_d       = idx_q + 1'b1;
            state_d     = STREAM;
`ifdef BURST_RD_STRIDE_EN
            addr_d      = addr_q + stride_q;
`endif
        end else if (state_q == STREAM && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BURST_RD_STRIDE_EN
            addr_q      <= '0;
            stride_q    <= '0;
`else
            base_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef BURST_RD_STRIDE_EN
            addr_q      <= addr_d;
            stride_q    <= stride_d;
`else
            base_q      <= base_d;
`endif
        end
    end
endmodule
